// File: rtl/seq_adder_ctrl.sv
// Multi-cycle wide adder: one N-bit slice adder sequenced over WORDS cycles, LSB slice first.
// Optional subtract mode is enabled by defining SEQ_ADDER_SUB_EN.
module seq_adder_ctrl #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 CLK,
    input  logic                 N_RESET,
    input  logic                 START,
    input  logic [N*WORDS-1:0]   A,
    input  logic [N*WORDS-1:0]   B,
    input  logic                 CIN,
    input  logic                 SUB,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [N*WORDS-1:0]   SUM,
    output logic                 COUT,
    output logic                 OVF
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic            r_carry;
    logic [IW-1:0]   r_idx;

    logic [W-1:0]    w_b_eff;
    logic            w_cin_eff;
    logic [N-1:0]    w_a_sl;
    logic [N-1:0]    w_b_sl;
    logic [N-1:0]    w_s_sl;
    logic            w_c_sl;
    logic [W-1:0]    w_res_nxt;
    logic            w_last;
    logic            w_accept;

`ifdef SEQ_ADDER_SUB_EN
    // Subtract is A + ~B + 1, so SUB forces the carry-in high
    assign w_b_eff   = SUB ? ~B : B;
    assign w_cin_eff = SUB | CIN;
`else
    logic w_unused_sub;
    assign w_unused_sub = SUB;
    assign w_b_eff      = B;
    assign w_cin_eff    = CIN;
`endif

    assign w_accept = START && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_a_sl = r_a[r_idx*N +: N];
        w_b_sl = r_b[r_idx*N +: N];
        {w_c_sl, w_s_sl} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{N{1'b0}}, r_carry};
        w_res_nxt = r_res;
        w_res_nxt[r_idx*N +: N] = w_s_sl;
        w_last = (r_idx == IW'(WORDS - 1));
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            SUM     <= '0;
            COUT    <= 1'b0;
            OVF     <= 1'b0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
            READY   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    DONE <= 1'b0;
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                        READY   <= 1'b0;
                        BUSY    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        READY   <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_nxt;
                    r_carry <= w_c_sl;
                    if (w_last) begin
                        SUM     <= w_res_nxt;
                        COUT    <= w_c_sl;
                        OVF     <= (r_a[W-1] == r_b[W-1]) && (w_res_nxt[W-1] != r_a[W-1]);
                        r_idx   <= '0;
                        r_state <= S_DONE;
                        DONE    <= 1'b1;
                        READY   <= 1'b1;
                        BUSY    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    DONE    <= 1'b0;
                    READY   <= 1'b1;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_adder_ctrl.md
Name: seq_adder_ctrl

Overview:
Multi-cycle controller that performs wide additions (W = N*WORDS bits) by sequencing one narrow N-bit slice adder (ripple, carry-in/carry-out) over WORDS clock cycles, least-significant slice first.
Saves area where a W-bit adder is too large and latency is acceptable.
Sits between a requesting datapath (operands plus START pulse) and the result consumer (DONE pulse plus held result).

Parameters:
N, 4, slice adder width in bits (>=1)
WORDS, 4, number of slices per operation (>=1); total width W = N*WORDS

Ports:
CLK  input  1  system clock, all state changes on rising edge
N_RESET  input  1  synchronous active-low reset, sampled on rising edge of CLK
START  input  1  request; accepted only when READY=1
A  input  W  operand A, sampled on accept edge only
B  input  W  operand B, sampled on accept edge only
CIN  input  1  carry-in for slice 0, sampled on accept edge only
SUB  input  1  subtract request, sampled on accept edge (see Optional Feature)
READY  output  1  high in IDLE and DONE states
BUSY  output  1  high in RUN state
DONE  output  1  single-cycle pulse, high in DONE state
SUM  output  W  registered result, held until next completion
COUT  output  1  carry out of the top slice, held with SUM
OVF  output  1  signed two's-complement overflow, held with SUM

Behaviour:
- Reset (N_RESET=0 at rising edge):
  - State goes to IDLE.
  - SUM=0, COUT=0, OVF=0, DONE=0, BUSY=0, READY=1.
  - Slice index, carry register and operand registers are cleared.
  - Reset overrides everything, including mid-RUN: the partial result is discarded, no DONE pulse, SUM keeps its reset value of 0.
- States: IDLE, RUN, DONE.
  - IDLE: if START=1, latch A, B, CIN (and SUB), set idx=0, carry=effective carry-in, go to RUN. Otherwise stay.
  - RUN: each cycle the slice adds A[idx*N +: N] + Beff[idx*N +: N] + carry. The N-bit sum goes into an internal result register at slice idx; carry is updated; idx increments.
  - RUN exit: on the edge processing idx=WORDS-1, copy the internal result to SUM, set COUT to the final carry, compute OVF, go to DONE.
  - DONE: DONE=1 for exactly one cycle. If START=1, accept a new operation (as in IDLE) and go to RUN; otherwise go to IDLE.
- Latency: START is accepted at edge k. DONE is high during the cycle after edge k+WORDS, and SUM/COUT/OVF become valid at that same edge.
- Throughput: one operation per WORDS+1 cycles when START is held high continuously.
- START while BUSY=1 is ignored. There is no queueing and no error flag. Operand changes during RUN have no effect.
- SUM, COUT and OVF change only on a completion edge or on reset, never during RUN.
- Arithmetic:
  - Beff = B; carry-in = CIN.
  - OVF = (A[W-1] == Beff[W-1]) && (SUM[W-1] != A[W-1]).
  - COUT is the raw carry out; no saturation.
- WORDS=1: RUN lasts one cycle; the block must still operate correctly.
- idx width is clog2(WORDS), minimum 1 bit. idx never exceeds WORDS-1.

Optional Feature:
Macro SEQ_ADDER_SUB_EN.
- Defined: if SUB=1 on the accept edge, Beff = ~B and carry-in is forced to 1 (CIN is ignored), giving A-B. COUT=1 means no borrow. OVF uses Beff as above.
- Not defined: the SUB port is present but ignored; operation is always A+B+CIN and no inversion logic is synthesised.

Test Plan:
- N=4, WORDS=4. A=0x00FF, B=0x0001, CIN=0, START pulsed at edge k:
  - BUSY=1 during the cycles after edges k..k+3.
  - DONE=1 only after edge k+4, with SUM=0x0100, COUT=0, OVF=0.
  - READY low during RUN.
- A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1, OVF=0. Then A=0x7FFF, B=0x0000, CIN=1 -> SUM=0x8000, COUT=0, OVF=1.
- With SEQ_ADDER_SUB_EN: A=0x0005, B=0x0007, SUB=1, CIN=0 -> SUM=0xFFFE, COUT=0, OVF=0. Without the macro, the same stimulus gives SUM=0x000C.
- START held high for 3 ops (A=1,2,3; B=0x10):
  - Ops accepted only on IDLE/DONE edges, at a spacing of 5 cycles.
  - Results 0x0011, 0x0012, 0x0013.
  - START pulses injected mid-RUN produce no extra DONE.
- Drive N_RESET=0 after 2 RUN cycles of 0x1234+0x1111:
  - Next cycle: READY=1, BUSY=0, SUM=0; no DONE pulse.
  - A subsequent op 0x1234+0x1111 gives SUM=0x2345.
- WORDS=1, N=8: 0x80+0x80 -> DONE 1 cycle after the RUN edge, with SUM=0x00, COUT=1, OVF=1.
